// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Qualifies the PLL lock flag, holds the system in reset until lock has
// been stable long enough, then releases a clean synchronous reset and
// produces the CPU clock-enable. Loss of lock re-asserts reset at once and
// leaves a sticky lock_lost flag behind.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int CE_DIV             = 10,
    parameter int CNT_W              = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic clear_lost,
    output logic sys_reset_n,
    output logic ready,
    output logic cpu_ce,
    output logic lock_lost
);

    localparam int DIV_W = $clog2(CE_DIV);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CE_DIV - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABLE    = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    logic             sync_meta;
    logic             locked_s;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lost_set;
    logic             stay_run;
    logic [DIV_W-1:0] div;
    logic             run_q;

    // Two-flop synchronizer bringing the asynchronous lock flag into clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    // Next-state and shared counter logic for lock qualification.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_set  = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (locked_s) begin
                    state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    lost_set  = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign stay_run = (state == RUN) && (state_nxt == RUN);

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered RUN decode so reset release and ready change exactly at the RUN boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= (state_nxt == RUN);
        end
    end

    assign sys_reset_n = run_q;
    assign ready       = run_q;

    // CPU clock-enable divider; idle at zero outside RUN, pulse on wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            cpu_ce <= 1'b0;
        end else if (stay_run) begin
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
            cpu_ce <= (div == DIV_LAST);
        end else begin
            div    <= '0;
            cpu_ce <= 1'b0;
        end
    end

    // Sticky lock-loss flag; a new loss wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_lost <= 1'b0;
        end else if (lost_set) begin
            lock_lost <= 1'b1;
        end else if (clear_lost) begin
            lock_lost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Self-checking bench for pll_reset_sequencer with short qualification
// parameters. Expected output vectors {sys_reset_n, ready, cpu_ce, lock_lost}
// are queued when stimulus is driven and compared after the next clock edge.
module tb_pll_reset_sequencer;

    localparam int LS  = 8;
    localparam int RH  = 4;
    localparam int CD  = 3;
    localparam int REL = 3 + LS + RH;

    typedef struct {
        logic       pll;
        logic       clr;
        logic [3:0] exp;
    } vec_t;

    logic clk;
    logic reset_n;
    logic pll_locked;
    logic clear_lost;
    logic sys_reset_n;
    logic ready;
    logic cpu_ce;
    logic lock_lost;

    logic [3:0] expq[$];
    vec_t       nominal[27];
    int         compared;
    int         mismatched;
    string      phase;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(LS),
        .RST_HOLD_CYCLES   (RH),
        .CE_DIV            (CD),
        .CNT_W             (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .clear_lost (clear_lost),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .cpu_ce     (cpu_ce),
        .lock_lost  (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops the oldest expected vector and compares it with the DUT outputs.
    task automatic checkOutput();
        logic [3:0] got;
        logic [3:0] want;
        got = {sys_reset_n, ready, cpu_ce, lock_lost};
        compared++;
        if (expq.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL %s: scoreboard empty, got %b", phase, got);
        end else begin
            want = expq.pop_front();
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL %s at %0t: sys/rdy/ce/lost got %b required %b",
                         phase, $time, got, want);
            end
        end
    endtask

    // Drives one cycle of inputs, queues the expectation, checks after the edge.
    task automatic applyStimulus(input logic pll, input logic clr, input logic sys,
                                 input logic ce, input logic lost);
        pll_locked = pll;
        clear_lost = clr;
        expq.push_back({sys, sys, ce, lost});
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    // Full qualification from WAIT_LOCK followed by runLen cycles in RUN.
    task automatic qualifyThenRun(input logic lost, input int runLen);
        for (int i = 1; i < REL; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, lost);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, lost);
        for (int j = 1; j <= runLen; j++)
            applyStimulus(1'b1, 1'b0, 1'b1, (j % CD) == 0, lost);
    endtask

    // Drops lock after j cycles in RUN; RUN persists two more edges, then exits.
    task automatic dropFromRun(input int j, input logic clrAtLeave, input logic lostBefore);
        applyStimulus(1'b0, 1'b0, 1'b1, ((j + 1) % CD) == 0, lostBefore);
        applyStimulus(1'b0, 1'b0, 1'b1, ((j + 2) % CD) == 0, lostBefore);
        applyStimulus(1'b0, clrAtLeave, 1'b0, 1'b0, 1'b1);
    endtask

    // Pulses reset_n between edges and checks the outputs drop immediately.
    task automatic asyncResetPulse();
        reset_n = 1'b0;
        #1;
        expq.push_back(4'b0000);
        checkOutput();
        #1;
        reset_n = 1'b1;
    endtask

    // Bounds the whole run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        compared   = 0;
        mismatched = 0;
        for (int e = 1; e <= 27; e++) begin
            nominal[e-1].pll = 1'b1;
            nominal[e-1].clr = 1'b0;
            nominal[e-1].exp = {e >= REL, e >= REL, (e >= REL + CD) && ((e - REL) % CD == 0), 1'b0};
        end

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        clear_lost = 1'b0;
        @(negedge clk);

        phase = "reset_hold";
        for (int i = 0; i < 6; i++) applyStimulus(i[0], 1'b0, 1'b0, 1'b0, 1'b0);
        pll_locked = 1'b0;
        reset_n    = 1'b1;
        phase = "idle_unlocked";
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        phase = "nominal";
        for (int k = 0; k < 27; k++) begin
            pll_locked = nominal[k].pll;
            clear_lost = nominal[k].clr;
            expq.push_back(nominal[k].exp);
            @(posedge clk);
            @(negedge clk);
            checkOutput();
        end

        phase = "loss_in_run";
        dropFromRun(12, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        phase = "relock_sticky";
        qualifyThenRun(1'b1, 7);
        phase = "clear_in_run";
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        phase = "set_beats_clear";
        dropFromRun(9, 1'b1, 1'b0);
        phase = "clear_idle";
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        phase = "glitch_stable";
        for (int e = 1; e < 23; e++)
            applyStimulus(!(e == 7 || e == 8), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 6; j++) applyStimulus(1'b1, 1'b0, 1'b1, (j % CD) == 0, 1'b0);
        dropFromRun(6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        phase = "reset_mid_hold";
        for (int e = 1; e <= 12; e++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        asyncResetPulse();
        phase = "requalify_after_reset";
        qualifyThenRun(1'b0, 7);

        phase = "reset_in_run";
        asyncResetPulse();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
